// File: rtl/lcd_frame_scheduler.sv
// lcd_frame_scheduler: per-frame sequencer for the shared lcd_write engine.
// Issues the CASET/RASET/RAMWR window words, then fetches and writes
// H_RES*V_RES pixels over a req/valid handshake. Image switches requested by
// the free-running switch timer are only applied at the frame boundary.
// Optional build macro LCD_TE_SYNC_EN: adds lcd_te and gates each frame start
// on a synchronised rising edge of the panel tearing-effect line.
module lcd_frame_scheduler #(
   parameter int unsigned H_RES         = 160,
   parameter int unsigned V_RES         = 240,
   parameter int unsigned SWITCH_CYCLES = 50000000,
   parameter int unsigned NUM_IMAGES    = 5
) (
   input  logic       clk_25MHz,
   input  logic       rst_n,
`ifdef LCD_TE_SYNC_EN
   input  logic       lcd_te,
`endif
   input  logic       init_done,
   input  logic       wr_done,
   output logic [8:0] wr_data,
   output logic       wr_en,
   output logic       pix_req,
   output logic [15:0] pix_index,
   input  logic       pix_valid,
   input  logic [8:0] pix_data,
   output logic [2:0] image_id,
   output logic       frame_start,
   output logic       busy
);

   localparam int unsigned NPIX     = H_RES * V_RES;
   localparam logic [15:0] LAST_PIX = 16'(NPIX - 1);
   localparam logic [15:0] XE       = 16'(H_RES - 1);
   localparam logic [15:0] YE       = 16'(V_RES - 1);
   localparam int unsigned TW       = (SWITCH_CYCLES > 1) ? $clog2(SWITCH_CYCLES) : 1;
   localparam logic [TW-1:0] TMAX   = TW'(SWITCH_CYCLES - 1);
   localparam logic [2:0] IMG_LAST  = 3'(NUM_IMAGES - 1);
   localparam logic [3:0] WIN_LAST  = 4'd10;

   typedef enum logic [2:0] {
      IDLE,
      WIN,
      FETCH,
      WRITE,
      FRAME_END,
      WAIT_TE
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    win_idx_q, win_idx_d;
   logic          wr_en_q, wr_en_d;
   logic [8:0]    wr_data_q, wr_data_d;
   logic          pix_req_q, pix_req_d;
   logic [15:0]   pix_index_q, pix_index_d;
   logic [2:0]    image_id_q, image_id_d;
   logic          frame_start_q, frame_start_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          switch_pending_q, switch_pending_d;
   logic          expire;

   // The pixel word's dc bit is always forced to 1, so the source's copy is unused.
   logic unused_pix_dc;
   assign unused_pix_dc = pix_data[8];

   // Address-window command set: column range 0..XE, row range 0..YE, then RAMWR.
   function automatic logic [8:0] win_word(input logic [3:0] idx);
      case (idx)
         4'd0:    win_word = 9'h02A;
         4'd1:    win_word = 9'h100;
         4'd2:    win_word = 9'h100;
         4'd3:    win_word = {1'b1, XE[15:8]};
         4'd4:    win_word = {1'b1, XE[7:0]};
         4'd5:    win_word = 9'h02B;
         4'd6:    win_word = 9'h100;
         4'd7:    win_word = 9'h100;
         4'd8:    win_word = {1'b1, YE[15:8]};
         4'd9:    win_word = {1'b1, YE[7:0]};
         default: win_word = 9'h02C;
      endcase
   endfunction

`ifdef LCD_TE_SYNC_EN
   logic te_s1_q, te_s2_q, te_prev_q;
   logic te_rise;

   // Two-flop synchroniser for lcd_te plus a delayed copy for edge detection.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         te_s1_q   <= 1'b0;
         te_s2_q   <= 1'b0;
         te_prev_q <= 1'b0;
      end else begin
         te_s1_q   <= lcd_te;
         te_s2_q   <= te_s1_q;
         te_prev_q <= te_s2_q;
      end
   end

   assign te_rise = te_s2_q & ~te_prev_q;
`endif

   // State and output registers, all cleared asynchronously.
   always_ff @(posedge clk_25MHz or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         win_idx_q        <= '0;
         wr_en_q          <= 1'b0;
         wr_data_q        <= '0;
         pix_req_q        <= 1'b0;
         pix_index_q      <= '0;
         image_id_q       <= '0;
         frame_start_q    <= 1'b0;
         timer_q          <= '0;
         switch_pending_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         win_idx_q        <= win_idx_d;
         wr_en_q          <= wr_en_d;
         wr_data_q        <= wr_data_d;
         pix_req_q        <= pix_req_d;
         pix_index_q      <= pix_index_d;
         image_id_q       <= image_id_d;
         frame_start_q    <= frame_start_d;
         timer_q          <= timer_d;
         switch_pending_q <= switch_pending_d;
      end
   end

   // Next-state, switch timer and registered-output computation.
   always_comb begin
      state_d          = state_q;
      win_idx_d        = win_idx_q;
      wr_en_d          = wr_en_q;
      wr_data_d        = wr_data_q;
      pix_req_d        = pix_req_q;
      pix_index_d      = pix_index_q;
      image_id_d       = image_id_q;
      frame_start_d    = 1'b0;
      timer_d          = timer_q;
      switch_pending_d = switch_pending_q;
      expire           = 1'b0;

      if (state_q != IDLE) begin
         if (timer_q == TMAX) begin
            timer_d          = '0;
            expire           = 1'b1;
            switch_pending_d = 1'b1;
         end else begin
            timer_d = timer_q + 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (init_done) begin
`ifdef LCD_TE_SYNC_EN
               state_d = WAIT_TE;
`else
               state_d       = WIN;
               win_idx_d     = '0;
               wr_en_d       = 1'b1;
               wr_data_d     = win_word(4'd0);
               frame_start_d = 1'b1;
`endif
            end
         end
`ifdef LCD_TE_SYNC_EN
         WAIT_TE: begin
            if (te_rise) begin
               state_d       = WIN;
               win_idx_d     = '0;
               wr_en_d       = 1'b1;
               wr_data_d     = win_word(4'd0);
               frame_start_d = 1'b1;
            end
         end
`endif
         WIN: begin
            if (wr_done) begin
               if (win_idx_q == WIN_LAST) begin
                  state_d     = FETCH;
                  wr_en_d     = 1'b0;
                  pix_index_d = '0;
                  pix_req_d   = 1'b1;
               end else begin
                  win_idx_d = win_idx_q + 4'd1;
                  wr_data_d = win_word(win_idx_q + 4'd1);
               end
            end
         end
         FETCH: begin
            if (pix_valid) begin
               wr_data_d = {1'b1, pix_data[7:0]};
               pix_req_d = 1'b0;
               wr_en_d   = 1'b1;
               state_d   = WRITE;
            end
         end
         WRITE: begin
            if (wr_done) begin
               wr_en_d = 1'b0;
               if (pix_index_q == LAST_PIX) begin
                  state_d = FRAME_END;
               end else begin
                  pix_index_d = pix_index_q + 16'd1;
                  pix_req_d   = 1'b1;
                  state_d     = FETCH;
               end
            end
         end
         FRAME_END: begin
            wr_en_d = 1'b0;
            // An expiry landing on this very cycle is honoured at this boundary.
            if (switch_pending_q || expire) begin
               image_id_d       = (image_id_q == IMG_LAST) ? 3'd0 : image_id_q + 3'd1;
               switch_pending_d = 1'b0;
            end
`ifdef LCD_TE_SYNC_EN
            state_d = WAIT_TE;
`else
            state_d       = WIN;
            win_idx_d     = '0;
            wr_en_d       = 1'b1;
            wr_data_d     = win_word(4'd0);
            frame_start_d = 1'b1;
`endif
         end
         default: state_d = IDLE;
      endcase

      // Losing init_done aborts the frame; image_id and the timer are kept.
      if (state_q != IDLE && !init_done) begin
         state_d       = IDLE;
         wr_en_d       = 1'b0;
         pix_req_d     = 1'b0;
         pix_index_d   = '0;
         frame_start_d = 1'b0;
      end
   end

   assign wr_data     = wr_data_q;
   assign wr_en       = wr_en_q;
   assign pix_req     = pix_req_q;
   assign pix_index   = pix_index_q;
   assign image_id    = image_id_q;
   assign frame_start = frame_start_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// tb_lcd_frame_scheduler: directed bench for lcd_frame_scheduler with a small
// 4x2 frame, a writer model (wr_done 3 cycles after each word) and a pixel
// source with a programmable reply delay. Build with LCD_TE_SYNC_EN defined
// to exercise the tearing-effect gating as well.
module tb_lcd_frame_scheduler;

   logic        clk_25MHz = 1'b0;
   logic        rst_n;
   logic        init_done;
   logic        wr_done;
   logic [8:0]  wr_data;
   logic        wr_en;
   logic        pix_req;
   logic [15:0] pix_index;
   logic        pix_valid;
   logic [8:0]  pix_data;
   logic [2:0]  image_id;
   logic        frame_start;
   logic        busy;
`ifdef LCD_TE_SYNC_EN
   logic        lcd_te;
`endif

   typedef struct {
      logic [8:0]  data;
      logic [15:0] idx;
   } wlog_t;

   wlog_t       wq[$];
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;
   int unsigned wcnt = 0;
   int unsigned pcnt = 0;
   int unsigned pix_delay = 5;
   int          fs_count = 0;
   int          img_changes = 0;
   int          img_viol = 0;
   int          fetch_viol = 0;
   logic [2:0]  img_prev = 3'd0;
   logic        wrapped = 1'b0;
   logic        req_prev = 1'b0;
   logic [15:0] req_idx = '0;
   logic [8:0]  win_exp [0:10] = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h103,
                                   9'h02B, 9'h100, 9'h100, 9'h100, 9'h101, 9'h02C};

   lcd_frame_scheduler #(
      .H_RES(4),
      .V_RES(2),
      .SWITCH_CYCLES(100),
      .NUM_IMAGES(5)
   ) dut (
      .clk_25MHz  (clk_25MHz),
      .rst_n      (rst_n),
`ifdef LCD_TE_SYNC_EN
      .lcd_te     (lcd_te),
`endif
      .init_done  (init_done),
      .wr_done    (wr_done),
      .wr_data    (wr_data),
      .wr_en      (wr_en),
      .pix_req    (pix_req),
      .pix_index  (pix_index),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .image_id   (image_id),
      .frame_start(frame_start),
      .busy       (busy)
   );

   // 25 MHz clock and cycle counter.
   always #20 clk_25MHz = ~clk_25MHz;
   always @(posedge clk_25MHz) cyc++;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_log(input int n, input int budget, input string tag);
      int k = 0;
      while (wq.size() < n && k < budget) begin
         @(negedge clk_25MHz);
         k++;
      end
      if (wq.size() < n) begin
         check_eq(tag, wq.size(), n);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $fatal(1, "timeout");
      end
   endtask

   // Writer model: completes each presented word 3 cycles later and logs it.
   always @(negedge clk_25MHz) begin
      if (!rst_n || wr_done) begin
         wr_done = 1'b0;
         wcnt    = 0;
      end else if (wr_en) begin
         wcnt++;
         if (wcnt == 3) begin
            wq.push_back('{wr_data, pix_index});
            wr_done = 1'b1;
         end
      end else begin
         wcnt = 0;
      end
   end

   // Pixel source: answers pix_req after pix_delay cycles, dc bit deliberately 0.
   always @(negedge clk_25MHz) begin
      if (!rst_n || pix_valid || !pix_req) begin
         pix_valid = 1'b0;
         pcnt      = 0;
      end else begin
         pcnt++;
         if (pcnt >= pix_delay) begin
            pix_data  = {1'b0, 8'hA5 ^ pix_index[7:0]};
            pix_valid = 1'b1;
         end
      end
   end

   // Protocol monitors: fetch wait behaviour and frame-aligned image switching.
   always @(negedge clk_25MHz) begin
      if (rst_n) begin
         if (frame_start) fs_count++;
         if (pix_req) begin
            if (wr_en) fetch_viol++;
            if (!req_prev) req_idx = pix_index;
            else if (pix_index != req_idx) fetch_viol++;
         end
         req_prev = pix_req;
         if (image_id != img_prev) begin
            img_changes++;
            if (!frame_start) img_viol++;
            if (image_id != ((img_prev == 3'd4) ? 3'd0 : img_prev + 3'd1)) img_viol++;
            if (img_prev == 3'd4) wrapped = 1'b1;
         end
         img_prev = image_id;
      end
   end

`ifdef LCD_TE_SYNC_EN
   int unsigned te_cyc = 0;
   int unsigned first_wr_cyc = 0;
   // Tearing-effect source: short high pulse every 150 cycles.
   initial begin
      lcd_te = 1'b0;
      forever begin
         repeat (140) @(negedge clk_25MHz);
         lcd_te = 1'b1;
         te_cyc = cyc;
         repeat (10) @(negedge clk_25MHz);
         lcd_te = 1'b0;
      end
   end
   // Records the first write enable seen after init.
   always @(negedge clk_25MHz) begin
      if (wr_en && first_wr_cyc == 0) first_wr_cyc = cyc;
   end
`endif

   initial begin
      logic [2:0] img_save;
      int         fs_before;
      int         k;

      rst_n     = 1'b0;
      init_done = 1'b0;
      wr_done   = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      repeat (3) @(negedge clk_25MHz);
      check_eq("rst_wr_en", wr_en, 0);
      check_eq("rst_wr_data", wr_data, 0);
      check_eq("rst_pix_req", pix_req, 0);
      check_eq("rst_pix_index", pix_index, 0);
      check_eq("rst_image_id", image_id, 0);
      check_eq("rst_frame_start", frame_start, 0);
      check_eq("rst_busy", busy, 0);
      rst_n = 1'b1;

      while (cyc < 10) @(negedge clk_25MHz);
      init_done = 1'b1;
      wait_log(19, 3000, "frame1_timeout");
      for (int i = 0; i < 11; i++)
         check_eq($sformatf("win_word%0d", i), wq[i].data, win_exp[i]);
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("pix_data%0d", i), wq[11+i].data, {1'b1, 8'hA5 ^ 8'(i)});
         check_eq($sformatf("pix_index%0d", i), wq[11+i].idx, i);
      end
      check_eq("fs_first_frame", fs_count, 1);
      repeat (4) @(negedge clk_25MHz);
      check_eq("fs_second_frame", fs_count, 2);
`ifdef LCD_TE_SYNC_EN
      check_eq("te_latency_ok", (first_wr_cyc >= te_cyc + 3) && (first_wr_cyc <= te_cyc + 4), 1);
`endif

      // Alternate slow (multi-expiry) and fast frames until image_id has wrapped.
      k = 0;
      while (img_changes < 6 && k < 12000) begin
         @(negedge clk_25MHz);
         pix_delay = (fs_count % 2 == 1) ? 25 : 2;
         k++;
      end
      check_eq("img_changes_ge6", img_changes >= 6, 1);
      check_eq("img_wrapped", wrapped, 1);
      check_eq("img_switch_rules", img_viol, 0);

      // Drop init_done while pixel 3 is being written.
      pix_delay = 5;
      k = 0;
      while (!(pix_index == 16'd3 && wr_en) && k < 3000) begin
         @(negedge clk_25MHz);
         k++;
      end
      check_eq("reach_pixel3", pix_index == 16'd3 && wr_en, 1);
      img_save  = image_id;
      init_done = 1'b0;
      @(negedge clk_25MHz);
      check_eq("drop_busy", busy, 0);
      check_eq("drop_wr_en", wr_en, 0);
      check_eq("drop_pix_req", pix_req, 0);
      check_eq("drop_pix_index", pix_index, 0);
      check_eq("drop_image_kept", image_id, img_save);
      repeat (3) @(negedge clk_25MHz);
      wq.delete();
      fs_before = fs_count;
      init_done = 1'b1;
      wait_log(1, 3000, "restart_timeout");
      check_eq("restart_word0", wq[0].data, 9'h02A);
      check_eq("restart_frame_start", fs_count, fs_before + 1);
      wait_log(12, 3000, "restart_pix_timeout");
      check_eq("restart_pix0_index", wq[11].idx, 0);
      check_eq("restart_pix0_data", wq[11].data, 9'h1A5);

      // Asynchronous reset in the middle of a pixel write.
      k = 0;
      while (!(pix_index == 16'd2 && wr_en) && k < 3000) begin
         @(negedge clk_25MHz);
         k++;
      end
      check_eq("reach_pixel2", pix_index == 16'd2 && wr_en, 1);
      #3 rst_n = 1'b0;
      #1;
      check_eq("arst_wr_en", wr_en, 0);
      check_eq("arst_pix_req", pix_req, 0);
      check_eq("arst_image_id", image_id, 0);
      check_eq("arst_pix_index", pix_index, 0);
      check_eq("arst_busy", busy, 0);

      check_eq("fetch_wait_rules", fetch_viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
